// File: rtl/bd_cmd_scheduler_pkg.sv
// Shared constants and channel FSM state type for the BD command scheduler.
package bd_cmd_scheduler_pkg;

    localparam int NUM_CH  = 4;
    localparam int CMD_W   = 44;

    localparam int CH_S2C0 = 0;
    localparam int CH_C2S0 = 1;
    localparam int CH_S2C1 = 2;
    localparam int CH_C2S1 = 3;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_PEND = 1'b1
    } ch_state_t;

endpackage

// File: rtl/bd_cmd_scheduler_rr_arbiter4.sv
// Four-way round-robin picker: search starts one past last_grant and wraps.
// Purely combinational; no backpressure, an empty request vector yields a zero grant.
module rr_arbiter4 (
    input  logic [3:0] req,
    input  logic [1:0] last_grant,
    output logic [3:0] grant,
    output logic [1:0] grant_idx
);

    logic [1:0] cand;
    logic       found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        cand      = '0;
        found     = 1'b0;
        // i == 4 wraps back to last_grant itself, so it has lowest priority
        for (int i = 1; i <= 4; i++) begin
            cand = last_grant + 2'(i);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/bd_cmd_scheduler.sv
// Round-robin issue of per-channel BD commands; one outstanding command per channel.
// Grant is same-cycle tready, command strobe follows 1 cycle later; output has no backpressure.
module bd_cmd_scheduler
    import bd_cmd_scheduler_pkg::*;
#(
    parameter int TIMEOUT = 4096
) (
    input  logic                      user_clk,
    input  logic                      user_reset_n,
    input  logic [NUM_CH*CMD_W-1:0]   s_axis_cmd_tdata,
    input  logic [NUM_CH-1:0]         s_axis_cmd_tvalid,
    output logic [NUM_CH-1:0]         s_axis_cmd_tready,
    input  logic [NUM_CH-1:0]         ch_enable,
    input  logic [NUM_CH-1:0]         bd_resp_valid,
    output logic [CMD_W-1:0]          m_axis_buffer_cmd_tdata,
    output logic                      m_axis_buffer_cmd_tvalid,
    output logic [1:0]                m_axis_buffer_cmd_tdest,
    output logic [NUM_CH-1:0]         ch_pending,
    output logic [NUM_CH-1:0]         timeout_err
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    ch_state_t         state_q [NUM_CH];
    ch_state_t         state_d [NUM_CH];
    logic [15:0]       cnt_q   [NUM_CH];
    logic [15:0]       cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] idle;
    logic [NUM_CH-1:0] eligible;
    logic [NUM_CH-1:0] grant;
    logic [NUM_CH-1:0] terr_d;
    logic [1:0]        grant_idx;
    logic [1:0]        last_grant;
    logic              any_grant;

    // Reset gating keeps tready low while the async reset is held
    assign eligible          = s_axis_cmd_tvalid & ch_enable & idle & {NUM_CH{user_reset_n}};
    assign s_axis_cmd_tready = grant;
    assign any_grant         = |grant;

    rr_arbiter4 u_arb (
        .req        (eligible),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    always_comb begin
        idle       = '0;
        ch_pending = '0;
        terr_d     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i]    = state_q[i];
            cnt_d[i]      = cnt_q[i];
            idle[i]       = (state_q[i] == CH_IDLE);
            ch_pending[i] = (state_q[i] == CH_PEND);
            case (state_q[i])
                CH_IDLE: begin
                    if (grant[i]) begin
                        state_d[i] = CH_PEND;
                        cnt_d[i]   = '0;
                    end
                end
                CH_PEND: begin
                    // A response on the expiry cycle wins over the abort
                    if (bd_resp_valid[i]) begin
                        state_d[i] = CH_IDLE;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = CH_IDLE;
                        terr_d[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 16'd1;
                    end
                end
                default: state_d[i] = CH_IDLE;
            endcase
        end
    end

    always_ff @(posedge user_clk or negedge user_reset_n) begin
        if (!user_reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= CH_IDLE;
                cnt_q[i]   <= '0;
            end
            timeout_err              <= '0;
            last_grant               <= 2'd3;
            m_axis_buffer_cmd_tvalid <= 1'b0;
            m_axis_buffer_cmd_tdata  <= '0;
            m_axis_buffer_cmd_tdest  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            timeout_err              <= terr_d;
            m_axis_buffer_cmd_tvalid <= any_grant;
            if (any_grant) begin
                last_grant              <= grant_idx;
                m_axis_buffer_cmd_tdata <= s_axis_cmd_tdata[grant_idx*CMD_W +: CMD_W];
                m_axis_buffer_cmd_tdest <= grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_bd_cmd_scheduler.sv
// Directed vector table plus hand-written timeout and reset sequences.
module tb_bd_cmd_scheduler;
    import bd_cmd_scheduler_pkg::*;

    localparam int TMO = 8;

    logic                    user_clk = 1'b0;
    logic                    user_reset_n;
    logic [NUM_CH*CMD_W-1:0] s_axis_cmd_tdata;
    logic [NUM_CH-1:0]       s_axis_cmd_tvalid;
    logic [NUM_CH-1:0]       s_axis_cmd_tready;
    logic [NUM_CH-1:0]       ch_enable;
    logic [NUM_CH-1:0]       bd_resp_valid;
    logic [CMD_W-1:0]        m_axis_buffer_cmd_tdata;
    logic                    m_axis_buffer_cmd_tvalid;
    logic [1:0]              m_axis_buffer_cmd_tdest;
    logic [NUM_CH-1:0]       ch_pending;
    logic [NUM_CH-1:0]       timeout_err;

    bd_cmd_scheduler #(.TIMEOUT(TMO)) dut (
        .user_clk                 (user_clk),
        .user_reset_n             (user_reset_n),
        .s_axis_cmd_tdata         (s_axis_cmd_tdata),
        .s_axis_cmd_tvalid        (s_axis_cmd_tvalid),
        .s_axis_cmd_tready        (s_axis_cmd_tready),
        .ch_enable                (ch_enable),
        .bd_resp_valid            (bd_resp_valid),
        .m_axis_buffer_cmd_tdata  (m_axis_buffer_cmd_tdata),
        .m_axis_buffer_cmd_tvalid (m_axis_buffer_cmd_tvalid),
        .m_axis_buffer_cmd_tdest  (m_axis_buffer_cmd_tdest),
        .ch_pending               (ch_pending),
        .timeout_err              (timeout_err)
    );

    always #5 user_clk = ~user_clk;

    typedef struct {
        logic [3:0] tv;
        logic [3:0] en;
        logic [3:0] rsp;
        logic [3:0] e_rdy;
        logic       e_vld;
        logic [1:0] e_dest;
        logic [3:0] e_pend;
        logic [3:0] e_terr;
    } vec_t;

    vec_t             vecs[$];
    logic [CMD_W-1:0] cmd_tab [NUM_CH];
    int               checks = 0;
    int               errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] tv, input logic [3:0] en, input logic [3:0] rsp,
                       input logic [3:0] rdy, input logic vld, input logic [1:0] dest,
                       input logic [3:0] pend, input logic [3:0] terr);
        vec_t v;
        v.tv = tv; v.en = en; v.rsp = rsp; v.e_rdy = rdy;
        v.e_vld = vld; v.e_dest = dest; v.e_pend = pend; v.e_terr = terr;
        vecs.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        cmd_tab[0] = 44'h0A0_0000_1111;
        cmd_tab[1] = 44'h0B0_0000_2222;
        cmd_tab[2] = 44'h0C0_0000_3333;
        cmd_tab[3] = 44'h123_4567_89AB;
        s_axis_cmd_tdata  = {cmd_tab[3], cmd_tab[2], cmd_tab[1], cmd_tab[0]};
        user_reset_n      = 1'b0;
        s_axis_cmd_tvalid = 4'b1111;
        ch_enable         = 4'b1111;
        bd_resp_valid     = 4'b0000;

        // round robin 0,1,2,3,0 with responses one cycle after each strobe
        add(4'b1111, 4'b1111, 4'b0000, 4'b0001, 0, 0, 4'b0000, 4'b0000);
        add(4'b1111, 4'b1111, 4'b0000, 4'b0010, 1, 0, 4'b0001, 4'b0000);
        add(4'b1111, 4'b1111, 4'b0001, 4'b0100, 1, 1, 4'b0011, 4'b0000);
        add(4'b1111, 4'b1111, 4'b0010, 4'b1000, 1, 2, 4'b0110, 4'b0000);
        add(4'b1111, 4'b1111, 4'b0100, 4'b0001, 1, 3, 4'b1100, 4'b0000);
        add(4'b0000, 4'b1111, 4'b1000, 4'b0000, 1, 0, 4'b1001, 4'b0000);
        add(4'b0000, 4'b1111, 4'b0001, 4'b0000, 0, 0, 4'b0001, 4'b0000);
        add(4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        // only ch0/ch2 enabled: alternate 2,0,2,0
        add(4'b1111, 4'b0101, 4'b0000, 4'b0100, 0, 0, 4'b0000, 4'b0000);
        add(4'b1111, 4'b0101, 4'b0100, 4'b0001, 1, 2, 4'b0100, 4'b0000);
        add(4'b1111, 4'b0101, 4'b0001, 4'b0100, 1, 0, 4'b0001, 4'b0000);
        add(4'b1111, 4'b0101, 4'b0100, 4'b0001, 1, 2, 4'b0100, 4'b0000);
        add(4'b0000, 4'b0101, 4'b0001, 4'b0000, 1, 0, 4'b0001, 4'b0000);
        add(4'b0000, 4'b0101, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        // single ch3 command, strobe exactly one cycle
        add(4'b1000, 4'b1111, 4'b0000, 4'b1000, 0, 0, 4'b0000, 4'b0000);
        add(4'b0000, 4'b1111, 4'b0000, 4'b0000, 1, 3, 4'b1000, 4'b0000);
        add(4'b0000, 4'b1111, 4'b1000, 4'b0000, 0, 0, 4'b1000, 4'b0000);
        add(4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        // ch1 response lands on the last count: no timeout_err
        add(4'b0010, 4'b1111, 4'b0000, 4'b0010, 0, 0, 4'b0000, 4'b0000);
        add(4'b0000, 4'b1111, 4'b0000, 4'b0000, 1, 1, 4'b0010, 4'b0000);
        for (int k = 1; k < TMO - 1; k++)
            add(4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0, 4'b0010, 4'b0000);
        add(4'b0000, 4'b1111, 4'b0010, 4'b0000, 0, 0, 4'b0010, 4'b0000);
        add(4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000);
        add(4'b0000, 4'b1111, 4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b0000);

        // reset state with requests present
        #12;
        chk("rst tready", 64'(s_axis_cmd_tready), 64'h0);
        chk("rst tvalid", 64'(m_axis_buffer_cmd_tvalid), 64'h0);
        chk("rst tdata",  64'(m_axis_buffer_cmd_tdata), 64'h0);
        chk("rst tdest",  64'(m_axis_buffer_cmd_tdest), 64'h0);
        chk("rst pend",   64'(ch_pending), 64'h0);
        chk("rst terr",   64'(timeout_err), 64'h0);
        @(negedge user_clk);
        user_reset_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            if (k != 0) @(negedge user_clk);
            s_axis_cmd_tvalid = vecs[k].tv;
            ch_enable         = vecs[k].en;
            bd_resp_valid     = vecs[k].rsp;
            #1;
            chk($sformatf("row%0d tready", k), 64'(s_axis_cmd_tready), 64'(vecs[k].e_rdy));
            chk($sformatf("row%0d tvalid", k), 64'(m_axis_buffer_cmd_tvalid), 64'(vecs[k].e_vld));
            chk($sformatf("row%0d pend", k), 64'(ch_pending), 64'(vecs[k].e_pend));
            chk($sformatf("row%0d terr", k), 64'(timeout_err), 64'(vecs[k].e_terr));
            if (vecs[k].e_vld) begin
                chk($sformatf("row%0d tdest", k), 64'(m_axis_buffer_cmd_tdest), 64'(vecs[k].e_dest));
                chk($sformatf("row%0d tdata", k), 64'(m_axis_buffer_cmd_tdata),
                    64'(cmd_tab[vecs[k].e_dest]));
            end
        end
        chk("ch3 literal tdata", 64'(cmd_tab[CH_C2S1]), 64'h123_4567_89AB);

        // ch2 timeout: pending for TMO cycles, one terr pulse, regrant at once
        @(negedge user_clk);
        s_axis_cmd_tvalid = 4'b0100;
        bd_resp_valid     = 4'b0000;
        #1;
        chk("tmo grant", 64'(s_axis_cmd_tready), 64'b0100);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge user_clk);
            #1;
            if (!ch_pending[2]) break;
            n++;
            if (timeout_err != 4'b0000 || s_axis_cmd_tready != 4'b0000)
                chk($sformatf("tmo pend cyc%0d terr/rdy", n),
                    64'({timeout_err, s_axis_cmd_tready}), 64'h0);
        end
        chk("tmo pend cycles", 64'(n), 64'(TMO));
        chk("tmo terr pulse", 64'(timeout_err), 64'b0100);
        chk("tmo regrant", 64'(s_axis_cmd_tready), 64'b0100);
        @(negedge user_clk);
        s_axis_cmd_tvalid = 4'b0000;
        bd_resp_valid     = 4'b0100;
        #1;
        chk("tmo terr once", 64'(timeout_err), 64'h0);
        chk("tmo repend", 64'(ch_pending), 64'b0100);
        chk("tmo re-strobe", 64'({m_axis_buffer_cmd_tvalid, m_axis_buffer_cmd_tdest}), 64'b110);
        @(negedge user_clk);
        bd_resp_valid = 4'b0000;
        #1;
        chk("tmo resp clears", 64'(ch_pending), 64'h0);

        // reset while ch3 and ch0 pend, ch0 strobe in flight
        @(negedge user_clk);
        s_axis_cmd_tvalid = 4'b1001;
        #1;
        chk("rr grant ch3", 64'(s_axis_cmd_tready), 64'b1000);
        @(negedge user_clk);
        #1;
        chk("rr grant ch0", 64'(s_axis_cmd_tready), 64'b0001);
        @(negedge user_clk);
        user_reset_n      = 1'b0;
        s_axis_cmd_tvalid = 4'b1111;
        #1;
        chk("midrst pend", 64'(ch_pending), 64'h0);
        chk("midrst strobe", 64'(m_axis_buffer_cmd_tvalid), 64'h0);
        chk("midrst terr", 64'(timeout_err), 64'h0);
        chk("midrst tready", 64'(s_axis_cmd_tready), 64'h0);
        @(negedge user_clk);
        user_reset_n = 1'b1;
        #1;
        chk("postrst grant ch0", 64'(s_axis_cmd_tready), 64'b0001);
        @(negedge user_clk);
        s_axis_cmd_tvalid = 4'b0000;
        #1;
        chk("postrst strobe", 64'({m_axis_buffer_cmd_tvalid, m_axis_buffer_cmd_tdest}), 64'b100);
        chk("postrst terr", 64'(timeout_err), 64'h0);
        chk("postrst pend", 64'(ch_pending), 64'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
